// File: rtl/ahb_cmd_sequencer.sv
// Command-queuing front end for the AHB-lite subsystem user port.
// Buffers commands, issues one at a time with fixed latency, and queues read data.
module ahb_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int WR_LAT    = 3,
    parameter int RD_LAT    = 4
) (
    input  logic                         Hclk,
    input  logic                         Hresetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_wr,
    input  logic [1:0]                   cmd_sel,
    input  logic [31:0]                  cmd_addr,
    input  logic [31:0]                  cmd_data1,
    input  logic [31:0]                  cmd_data2,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_data,
    output logic [1:0]                   rsp_sel,
    output logic                         enable,
    output logic                         Wr,
    output logic [1:0]                   slave_sel,
    output logic [31:0]                  addr,
    output logic [31:0]                  data_in_1,
    output logic [31:0]                  data_in_2,
    input  logic [31:0]                  d_out,
    output logic                         busy,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count
);

    localparam int CAW     = $clog2(CMD_DEPTH);
    localparam int RAW     = $clog2(RSP_DEPTH);
    localparam int MAX_LAT = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int LW      = $clog2(MAX_LAT + 1);

    localparam logic [LW-1:0] WR_LAT_C = LW'(WR_LAT);
    localparam logic [LW-1:0] RD_LAT_C = LW'(RD_LAT);
    localparam logic [LW-1:0] CNT_ONE  = LW'(1);

    typedef struct packed {
        logic        wr;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] data1;
        logic [31:0] data2;
    } cmd_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } rsp_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    cmd_t           cmd_mem [CMD_DEPTH];
    logic [CAW:0]   cmd_wptr;
    logic [CAW:0]   cmd_rptr;
    cmd_t           cmd_head;
    logic           cmd_empty;
    logic           cmd_full;
    logic           cmd_push;

    rsp_t           rsp_mem [RSP_DEPTH];
    logic [RAW:0]   rsp_wptr;
    logic [RAW:0]   rsp_rptr;
    rsp_t           rsp_head;
    logic           rsp_full;
    logic           rsp_pop;

    state_t         state;
    state_t         next_state;
    logic [LW-1:0]  cnt;
    logic [LW-1:0]  cnt_next;
    logic           issue;
    logic           capture;

    assign cmd_empty = (cmd_wptr == cmd_rptr);
    assign cmd_full  = (cmd_wptr[CAW] != cmd_rptr[CAW]) &&
                       (cmd_wptr[CAW-1:0] == cmd_rptr[CAW-1:0]);
    assign cmd_ready = ~cmd_full;
    assign cmd_count = cmd_wptr - cmd_rptr;
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_head  = cmd_mem[cmd_rptr[CAW-1:0]];

    assign rsp_valid = (rsp_wptr != rsp_rptr);
    assign rsp_full  = (rsp_wptr[RAW] != rsp_rptr[RAW]) &&
                       (rsp_wptr[RAW-1:0] == rsp_rptr[RAW-1:0]);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_head  = rsp_mem[rsp_rptr[RAW-1:0]];
    // Gated so the head reads as zero whenever the queue is empty, including after reset.
    assign rsp_data  = rsp_valid ? rsp_head.data : '0;
    assign rsp_sel   = rsp_valid ? rsp_head.sel  : '0;

    assign enable = (state == ISSUE);
    assign busy   = (state != IDLE);

    always_ff @(posedge Hclk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wptr[CAW-1:0]] <= '{wr: cmd_wr, sel: cmd_sel, addr: cmd_addr,
                                            data1: cmd_data1, data2: cmd_data2};
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            cmd_wptr <= '0;
            cmd_rptr <= '0;
        end else begin
            if (cmd_push) cmd_wptr <= cmd_wptr + (CAW+1)'(1);
            if (issue)    cmd_rptr <= cmd_rptr + (CAW+1)'(1);
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // A read is only issued when a response slot is free, so the response queue never overflows.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        issue      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_empty && (cmd_head.wr || !rsp_full)) begin
                    issue      = 1'b1;
                    next_state = ISSUE;
                    cnt_next   = cmd_head.wr ? WR_LAT_C : RD_LAT_C;
                end
            end
            ISSUE: begin
                if (cnt == CNT_ONE) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                    capture    = ~Wr;
                end else begin
                    next_state = WAIT;
                    cnt_next   = cnt - CNT_ONE;
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    next_state = IDLE;
                    capture    = ~Wr;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Wr        <= 1'b0;
            slave_sel <= '0;
            addr      <= '0;
            data_in_1 <= '0;
            data_in_2 <= '0;
        end else if (issue) begin
            Wr        <= cmd_head.wr;
            slave_sel <= cmd_head.sel;
            addr      <= cmd_head.addr;
            data_in_1 <= cmd_head.data1;
            data_in_2 <= cmd_head.data2;
        end
    end

    always_ff @(posedge Hclk) begin
        if (capture) begin
            rsp_mem[rsp_wptr[RAW-1:0]] <= '{sel: slave_sel, data: d_out};
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            rsp_wptr <= '0;
            rsp_rptr <= '0;
        end else begin
            if (capture) rsp_wptr <= rsp_wptr + (RAW+1)'(1);
            if (rsp_pop) rsp_rptr <= rsp_rptr + (RAW+1)'(1);
        end
    end

endmodule

// File: tb/tb_ahb_cmd_sequencer.sv
// Directed self-checking bench for ahb_cmd_sequencer with a small memory-backed
// subsystem model: writes store data_in_1 + data_in_2, reads return the stored word.
module tb_ahb_cmd_sequencer;

    logic        Hclk;
    logic        Hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [1:0]  cmd_sel;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data1;
    logic [31:0] cmd_data2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_sel;
    logic        enable;
    logic        Wr;
    logic [1:0]  slave_sel;
    logic [31:0] addr;
    logic [31:0] data_in_1;
    logic [31:0] data_in_2;
    logic [31:0] d_out;
    logic        busy;
    logic [2:0]  cmd_count;

    int errorCount = 0;
    int checkCount = 0;

    logic [31:0] mem [64];
    logic [1:0]  expSel[$];
    logic [31:0] expData[$];

    ahb_cmd_sequencer #(
        .CMD_DEPTH(4), .RSP_DEPTH(4), .WR_LAT(3), .RD_LAT(4)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_data1(cmd_data1), .cmd_data2(cmd_data2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_sel(rsp_sel),
        .enable(enable), .Wr(Wr), .slave_sel(slave_sel), .addr(addr),
        .data_in_1(data_in_1), .data_in_2(data_in_2), .d_out(d_out),
        .busy(busy), .cmd_count(cmd_count)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // Unwritten locations read back as 0xC0DE_0000 + {sel, addr[5:2]}.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    end

    always @(posedge Hclk) begin
        if (enable && Wr) mem[{slave_sel, addr[5:2]}] <= data_in_1 + data_in_2;
    end

    assign d_out = mem[{slave_sel, addr[5:2]}];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic wr, input logic [1:0] sel,
                                 input logic [31:0] a, input logic [31:0] d1, input logic [31:0] d2);
        cmd_valid = valid;
        cmd_wr    = wr;
        cmd_sel   = sel;
        cmd_addr  = a;
        cmd_data1 = d1;
        cmd_data2 = d2;
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (!(busy == 1'b0 && cmd_count == 3'd0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("idle_reached", {31'b0, (n < budget)}, 32'd1);
    endtask

    task automatic drainResponses(input int count, input int budget);
        int got = 0;
        int n = 0;
        rsp_ready = 1'b1;
        while (got < count && n < budget) begin
            if (rsp_valid) begin
                checkOutput("order_sel", {30'b0, rsp_sel}, {30'b0, expSel.pop_front()});
                checkOutput("order_data", rsp_data, expData.pop_front());
                got++;
            end
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        checkOutput("drain_count", 32'(got), 32'(count));
    endtask

    initial begin
        Hresetn   = 1'b1;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        #2 Hresetn = 1'b0;
        #1;
        checkOutput("rst_enable", {31'b0, enable}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("rst_cmd_count", {29'b0, cmd_count}, 32'd0);
        checkOutput("rst_addr", addr, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        tick();
        tick();
        Hresetn = 1'b1;

        // Reset during the WAIT phase of a read discards it without a response.
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h4, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        tick();
        checkOutput("mid_issue_enable", {31'b0, enable}, 32'd1);
        tick();
        checkOutput("mid_wait_busy", {31'b0, busy}, 32'd1);
        Hresetn = 1'b0;
        #1;
        checkOutput("mid_rst_enable", {31'b0, enable}, 32'd0);
        checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("mid_rst_cmd_count", {29'b0, cmd_count}, 32'd0);
        checkOutput("mid_rst_Wr_sel", {29'b0, Wr, slave_sel}, 32'd0);
        Hresetn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checkOutput("discarded_no_rsp", {31'b0, rsp_valid}, 32'd0);

        // Single write.
        applyStimulus(1'b1, 1'b1, 2'd2, 32'h10, 32'hA5A5_0001, 32'h0000_0002);
        tick();
        checkOutput("wr_queued_count", {29'b0, cmd_count}, 32'd1);
        checkOutput("wr_not_yet_enable", {31'b0, enable}, 32'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        tick();
        checkOutput("wr_enable", {31'b0, enable}, 32'd1);
        checkOutput("wr_busy0", {31'b0, busy}, 32'd1);
        checkOutput("wr_Wr", {31'b0, Wr}, 32'd1);
        checkOutput("wr_sel", {30'b0, slave_sel}, 32'd2);
        checkOutput("wr_addr", addr, 32'h10);
        checkOutput("wr_d1", data_in_1, 32'hA5A5_0001);
        checkOutput("wr_d2", data_in_2, 32'h0000_0002);
        checkOutput("wr_popped", {29'b0, cmd_count}, 32'd0);
        tick();
        checkOutput("wr_enable_drop", {31'b0, enable}, 32'd0);
        checkOutput("wr_busy1", {31'b0, busy}, 32'd1);
        tick();
        checkOutput("wr_busy2", {31'b0, busy}, 32'd1);
        checkOutput("wr_addr_held", addr, 32'h10);
        tick();
        checkOutput("wr_retired", {31'b0, busy}, 32'd0);
        checkOutput("wr_no_rsp", {31'b0, rsp_valid}, 32'd0);
        checkOutput("wr_d1_held", data_in_1, 32'hA5A5_0001);

        // Write then read to the same location; period between issues is WR_LAT+1.
        applyStimulus(1'b1, 1'b1, 2'd2, 32'h10, 32'hA5A5_0001, 32'h0000_0002);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 32'h0);
        tick();
        checkOutput("wr2_enable", {31'b0, enable}, 32'd1);
        checkOutput("push_pop_count1", {29'b0, cmd_count}, 32'd1);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("wr2_retired", {31'b0, busy}, 32'd0);
        tick();
        checkOutput("rd_enable", {31'b0, enable}, 32'd1);
        checkOutput("rd_Wr", {31'b0, Wr}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("rd_not_early", {31'b0, rsp_valid}, 32'd0);
        tick();
        checkOutput("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        checkOutput("rd_rsp_data", rsp_data, 32'hA5A5_0003);
        checkOutput("rd_rsp_sel", {30'b0, rsp_sel}, 32'd2);
        checkOutput("rd_retired", {31'b0, busy}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("rd_popped", {31'b0, rsp_valid}, 32'd0);

        // Fill the response queue with four reads, then stall a fifth behind it.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 2'(k), 32'(4 * k), 32'h0, 32'h0);
            tick();
        end
        checkOutput("fill_count", {29'b0, cmd_count}, 32'd3);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        waitIdle(80);
        checkOutput("fill_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        checkOutput("fill_head_sel", {30'b0, rsp_sel}, 32'd0);
        checkOutput("fill_head_data", rsp_data, 32'hC0DE_0000);
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 1'b0, 2'd3, 32'h20 + 32'(4 * j), 32'h0, 32'h0);
            tick();
        end
        checkOutput("full_count", {29'b0, cmd_count}, 32'd4);
        checkOutput("full_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        checkOutput("stall_busy", {31'b0, busy}, 32'd0);
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h0, 32'h0000_FFFF, 32'h0);
        tick();
        checkOutput("full_push_blocked", {29'b0, cmd_count}, 32'd4);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        tick();
        checkOutput("stall_enable", {31'b0, enable}, 32'd0);
        checkOutput("stall_busy2", {31'b0, busy}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("pop_new_head_sel", {30'b0, rsp_sel}, 32'd1);
        checkOutput("pop_new_head_data", rsp_data, 32'hC0DE_0011);
        checkOutput("pop_edge_busy", {31'b0, busy}, 32'd0);
        tick();
        checkOutput("unstall_enable", {31'b0, enable}, 32'd1);
        checkOutput("unstall_sel", {30'b0, slave_sel}, 32'd3);
        checkOutput("unstall_addr", addr, 32'h20);
        checkOutput("unstall_count", {29'b0, cmd_count}, 32'd3);
        checkOutput("unstall_ready", {31'b0, cmd_ready}, 32'd1);
        expSel  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        expData = '{32'hC0DE_0011, 32'hC0DE_0022, 32'hC0DE_0033,
                    32'hC0DE_0038, 32'hC0DE_0039, 32'hC0DE_003A, 32'hC0DE_003B};
        drainResponses(7, 120);
        waitIdle(40);

        // Push coinciding with an issue pop at occupancy 2; responses keep command order.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h30, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h34, 32'h0, 32'h0);
        tick();
        checkOutput("ord_a_enable", {31'b0, enable}, 32'd1);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h38, 32'h0, 32'h0);
        tick();
        checkOutput("ord_count2", {29'b0, cmd_count}, 32'd2);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("ord_a_retired", {31'b0, busy}, 32'd0);
        applyStimulus(1'b1, 1'b0, 2'd3, 32'h3C, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        checkOutput("ord_b_enable", {31'b0, enable}, 32'd1);
        checkOutput("ord_b_sel", {30'b0, slave_sel}, 32'd1);
        checkOutput("ord_push_pop_count2", {29'b0, cmd_count}, 32'd2);
        expSel  = '{2'd0, 2'd1, 2'd2, 2'd3};
        expData = '{32'hC0DE_000C, 32'hC0DE_001D, 32'hC0DE_002E, 32'hC0DE_003F};
        drainResponses(4, 80);
        waitIdle(40);
        checkOutput("end_rsp_empty", {31'b0, rsp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ahb_cmd_sequencer.md
# ahb_cmd_sequencer

Command-queuing front end that sits directly upstream of the AHB-lite subsystem top (`AHB_module`). It buffers user transactions in a command FIFO, issues them one at a time to the subsystem user port (`enable`, `data_in_1`, `data_in_2`, `addr`, `Wr`, `slave_sel`), and waits a fixed, parameterised latency for each one. Read data is captured from `d_out` into a response FIFO with a valid/ready handshake, so upstream logic never has to track subsystem timing.

## Interface
Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of 2, ≥2
- RSP_DEPTH, 4, response FIFO entries; power of 2, ≥2
- WR_LAT, 3, cycles from issue to write completion; ≥1
- RD_LAT, 4, cycles from issue to `d_out` valid; ≥1

Ports:
- Hclk  in  1  clock; all logic on rising edge
- Hresetn  in  1  reset; one clock, asynchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_wr  in  1  1 = write, 0 = read
- cmd_sel  in  2  target slave 0..3
- cmd_addr  in  32  address
- cmd_data1  in  32  write operand 1
- cmd_data2  in  32  write operand 2
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  read data at FIFO head
- rsp_sel  out  2  slave that produced the head entry
- enable  out  1  one-cycle issue strobe to the subsystem
- Wr, slave_sel, addr, data_in_1, data_in_2  out  1/2/32/32/32  registered command fields
- d_out  in  32  subsystem read data
- busy  out  1  FSM not in IDLE
- cmd_count  out  clog2(CMD_DEPTH)+1  command FIFO occupancy

## Operation
- Command FIFO:
  - Push on `cmd_valid && cmd_ready`.
  - `cmd_ready = (cmd_count != CMD_DEPTH)`.
  - Pop only in IDLE when an issue occurs.
- FSM has three states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when the FIFO is non-empty and the head is either a write or the response FIFO is not full. On that edge, pop the head and register `Wr`, `slave_sel`, `addr`, `data_in_1`, `data_in_2`. Set the counter to `LAT = cmd_wr ? WR_LAT : RD_LAT`.
  - ISSUE: `enable = 1` for exactly this cycle.
    - If `LAT == 1`: go to IDLE at the next edge; a read captures at that edge.
    - Otherwise: go to WAIT and load `cnt = LAT-1`.
  - WAIT: decrement `cnt` each edge. When `cnt == 1` at an edge, go to IDLE; a read captures at that edge.
- Read capture pushes `{slave_sel, d_out}` into the response FIFO. A write pushes nothing.
- Command fields stay stable from the ISSUE edge until the next ISSUE edge.
- Response FIFO:
  - Pop on `rsp_valid && rsp_ready`.
  - `rsp_data`/`rsp_sel` show the head entry, not registered beyond FIFO storage.
  - It cannot overflow: one transaction in flight, and a read is issued only if a slot is free.
- Only one transaction is outstanding at a time. Ordering is strictly FIFO.
- Boundary conditions:
  - Push and pop on the command FIFO in the same cycle: both occur and occupancy is unchanged.
  - Push into an empty FIFO: the entry is not issuable until the next cycle.
  - Full FIFO: `cmd_ready = 0`, so a push is impossible regardless of a same-cycle pop.
  - Response FIFO full with a read at head: the FSM stalls in IDLE. It issues on the first edge where not-full holds, including the cycle after a pop.
  - Capture edge coinciding with a response pop: both take effect.
  - Pointers wrap modulo depth, with an extra bit to distinguish full from empty.
- Reset, including mid-transaction:
  - FSM returns to IDLE, both FIFOs empty, counter 0.
  - The in-flight command is discarded with no response.
  - All outputs 0: `enable`, `Wr`, `slave_sel`, `addr`, `data_in_*`, `busy`, `rsp_valid`, `rsp_data`, `rsp_sel`, `cmd_count`.
  - `cmd_ready = 1`.

## Timing
- Issue latency: a command pushed at edge N with the FSM in IDLE gives `enable` high during cycle N+1→N+2.
- With issue edge E0, read data is sampled at edge E0+RD_LAT and `rsp_valid` rises after that edge. Writes retire at E0+WR_LAT.
- After retirement, the FSM spends one IDLE cycle before the next issue. Back-to-back period is LAT+1 cycles.
- `busy` is high from E0 up to the retire edge.
- `enable` is never high in two consecutive cycles.

## Test plan
- Reset mid-WAIT of a read → `enable = 0`, `busy = 0`, `rsp_valid = 0`, `cmd_count = 0` immediately. Push one command after release → issue proceeds normally.
- Single write (`sel = 2`, `addr = 0x10`, `data = 0xA5A5_0001`/`0x0000_0002`) → `enable` pulses one cycle, fields held, `busy` high for 3 cycles, no response.
- Write then read to `sel = 2`, `addr = 0x10`, with the subsystem model returning `0xA5A5_0003` → `rsp_valid` rises exactly RD_LAT edges after the read issue, with `rsp_data = 0xA5A5_0003` and `rsp_sel = 2`.
- Fill with 4 reads while `rsp_ready = 0` → `cmd_ready` falls at 4 entries and 4 responses are stored. A 5th read stalls with `busy = 0` until one `rsp_ready` pulse; then it issues on the next edge.
- Continuous push with a simultaneous issue-pop at `cmd_count = 2` → count stays 2. Responses return in command order across slaves 0..3.
